// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the decoder.
//
// Walks a program counter through RAM one byte per access (ADDR then CAPTURE,
// two cycles per byte) and assembles INSTR_BYTES bytes into one instruction
// word, byte 0 in the most significant position. Completed instructions are
// queued with their start address in a FIFO_DEPTH-entry FIFO drained through
// a valid/ready handshake. A branch flushes the queue and any partial word.
//
// Optional feature: define FETCH_STATS_EN to add a 16-bit push counter
// output (fetch_count).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   run               fetch enable (0 pauses between bytes)
//   branch_valid      redirect request; branch_target is the new PC
//   mem_address       RAM address (registered)
//   mem_out_en        RAM read enable (registered)
//   mem_write_en      RAM write enable, tied low
//   mem_data          RAM read data, valid during CAPTURE
//   instr_valid       queue head valid
//   instr_ready       decoder accepts the head
//   instr, instr_pc   head instruction word and its first-byte address
//   fetch_count       pushes since reset (FETCH_STATS_EN only)
//
// state   | meaning
// IDLE    | no access; waits for run and queue space
// ADDR    | address driven, read enable high
// CAPTURE | read data latched into the assembly slot on exit
module fetch_unit #(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 8,
  parameter int INSTR_BYTES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             run,
  input  logic                             branch_valid,
  input  logic [ADDR_BITS-1:0]             branch_target,
  output logic [ADDR_BITS-1:0]             mem_address,
  output logic                             mem_out_en,
  output logic                             mem_write_en,
  input  logic [DATA_BITS-1:0]             mem_data,
  output logic                             instr_valid,
  input  logic                             instr_ready,
  output logic [INSTR_BYTES*DATA_BITS-1:0] instr,
  output logic [ADDR_BITS-1:0]             instr_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]                      fetch_count
`endif
);

  localparam int IW    = INSTR_BYTES * DATA_BITS;
  localparam int IDX_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTR_BYTES - 1);

  typedef enum logic [1:0] {IDLE, ADDR, CAPTURE} state_t;

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] pc, pc_next, start_pc, push_pc;
  logic [IDX_W-1:0]     byte_idx, byte_idx_next;
  logic [DATA_BITS-1:0] asm_q [INSTR_BYTES];
  logic [IW-1:0]        asm_word;
  logic [IW-1:0]        fifo_instr [FIFO_DEPTH];
  logic [ADDR_BITS-1:0] fifo_pc [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]     count, count_next;
  logic                 capture, last_byte, push, pop, can_start;
  logic [ADDR_BITS-1:0] mem_address_next;
  logic                 mem_out_en_next;
  logic [IW-1:0]        head_instr_next;
  logic [ADDR_BITS-1:0] head_pc_next;

  assign mem_write_en = 1'b0;

  assign capture       = (state == CAPTURE);
  assign last_byte     = (byte_idx == LAST_IDX);
  assign push          = capture && last_byte;
  assign pop           = instr_valid && instr_ready;
  assign count_next    = count + CNT_W'(push) - CNT_W'(pop);
  assign rd_ptr_next   = rd_ptr + PTR_W'(pop);
  assign pc_next       = capture ? pc + 1'b1 : pc;
  assign byte_idx_next = !capture ? byte_idx : (last_byte ? '0 : byte_idx + 1'b1);
  assign push_pc       = (byte_idx == '0) ? pc : start_pc;
  // Space is only needed when a new instruction would start; counting the
  // push of this edge guarantees a started instruction never overflows.
  assign can_start     = run && ((byte_idx_next != '0) || (count_next < CNT_W'(FIFO_DEPTH)));

  always_comb begin
    asm_word = '0;
    for (int i = 0; i < INSTR_BYTES; i++) begin
      asm_word[(INSTR_BYTES-1-i)*DATA_BITS +: DATA_BITS] =
        (byte_idx == IDX_W'(i)) ? mem_data : asm_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || branch_valid) state <= IDLE;
    else                       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = can_start ? ADDR : IDLE;
      ADDR:    state_next = CAPTURE;
      CAPTURE: state_next = can_start ? ADDR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_out_en_next  = (state_next != IDLE);
    mem_address_next = (state_next == ADDR) ? pc_next : mem_address;
  end

  // Next queue head: the word being pushed when it lands in an empty (or
  // emptying) queue, otherwise the stored entry at the next read pointer.
  always_comb begin
    head_instr_next = '0;
    head_pc_next    = '0;
    if (count_next != '0) begin
      if ((count == '0) || ((count == CNT_W'(1)) && pop)) begin
        head_instr_next = asm_word;
        head_pc_next    = push_pc;
      end else begin
        head_instr_next = fifo_instr[rd_ptr_next];
        head_pc_next    = fifo_pc[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || branch_valid) begin
      pc          <= reset ? '0 : branch_target;
      byte_idx    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mem_out_en  <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      if (reset) begin
        start_pc    <= '0;
        mem_address <= '0;
      end
    end else begin
      pc          <= pc_next;
      byte_idx    <= byte_idx_next;
      if (capture && (byte_idx == '0)) start_pc <= pc;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr      <= rd_ptr_next;
      count       <= count_next;
      mem_address <= mem_address_next;
      mem_out_en  <= mem_out_en_next;
      instr_valid <= (count_next != '0);
      instr       <= head_instr_next;
      instr_pc    <= head_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !branch_valid) begin
      if (push) begin
        fifo_instr[wr_ptr] <= asm_word;
        fifo_pc[wr_ptr]    <= push_pc;
      end
      if (capture) begin
        for (int i = 0; i < INSTR_BYTES; i++) begin
          if (byte_idx == IDX_W'(i)) asm_q[i] <= mem_data;
        end
      end
    end
  end

`ifdef FETCH_STATS_EN
  // Counts pushes that actually happen; a push dropped by a branch is not one.
  always_ff @(posedge clk) begin
    if (reset)                     fetch_count <= '0;
    else if (!branch_valid && push) fetch_count <= fetch_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int IB = 2;
  localparam int FD = 2;

  logic clk = 1'b0;
  logic reset, run, branch_valid, instr_ready;
  logic [AB-1:0] branch_target, mem_address, instr_pc;
  logic mem_out_en, mem_write_en, instr_valid;
  logic [DB-1:0] mem_data = '0;
  logic [IB*DB-1:0] instr;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count;
`endif

  int total = 0;
  int bad = 0;
  logic [DB-1:0] ram [256];

  fetch_unit #(.ADDR_BITS(AB), .DATA_BITS(DB), .INSTR_BYTES(IB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .run(run),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .mem_address(mem_address), .mem_out_en(mem_out_en), .mem_write_en(mem_write_en),
    .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: address presented in ADDR, data valid in CAPTURE.
  always @(posedge clk) if (mem_out_en) mem_data <= ram[mem_address];

  function automatic logic [IB*DB-1:0] exp_word(input logic [AB-1:0] p);
    logic [IB*DB-1:0] w;
    logic [AB-1:0] a;
    w = '0;
    for (int k = 0; k < IB; k++) begin
      a = p + AB'(k);
      w = (w << DB) | (IB*DB)'(ram[a]);
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; branch_valid = 1'b0; instr_ready = 1'b0; branch_target = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; branch_valid = 1'b1; branch_target = 8'h55; instr_ready = 1'b1;
    step();
    total++; if (mem_address !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h want=00", mem_address); end
    total++; if (mem_out_en !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", mem_out_en); end
    total++; if (mem_write_en !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", mem_write_en); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
    total++; if (instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h want=0000", instr); end
    total++; if (instr_pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h want=00", instr_pc); end
    branch_valid = 1'b0;
    step();
    total++; if (mem_out_en !== 1'b0) begin bad++; $display("FAIL reset_hold_oe got=%b want=0", mem_out_en); end
    reset = 1'b0; run = 1'b0;
    step();
    total++; if (mem_out_en !== 1'b0) begin bad++; $display("FAIL idle_norun_oe got=%b want=0", mem_out_en); end
  endtask

  task automatic test_basic();
    logic [15:0] wq[$];
    logic [7:0]  pq[$];
    int first_edge;
    first_edge = -1;
    do_reset();
    instr_ready = 1'b1; run = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (instr_valid) begin
        if (first_edge < 0) first_edge = n;
        wq.push_back(instr); pq.push_back(instr_pc);
      end
      if (wq.size() >= 3) break;
    end
    total++; if (first_edge != 5) begin bad++; $display("FAIL basic_latency got=%0d want=5", first_edge); end
    total++;
    if (wq.size() < 3) begin bad++; $display("FAIL basic_timeout got=%0d want=3 instrs", wq.size()); end
    else begin
      total++; if (wq[0] !== 16'h1122 || pq[0] !== 8'h00) begin bad++; $display("FAIL basic_i0 got=%h@%h want=1122@00", wq[0], pq[0]); end
      total++; if (wq[1] !== 16'h3344 || pq[1] !== 8'h02) begin bad++; $display("FAIL basic_i1 got=%h@%h want=3344@02", wq[1], pq[1]); end
      total++; if (wq[2] !== 16'h5566 || pq[2] !== 8'h04) begin bad++; $display("FAIL basic_i2 got=%h@%h want=5566@04", wq[2], pq[2]); end
    end
    total++; if (mem_write_en !== 1'b0) begin bad++; $display("FAIL basic_we got=%b want=0", mem_write_en); end
  endtask

  task automatic test_backpressure();
    logic [15:0] wq[$];
    logic [7:0]  pq[$];
    bit addr_seen;
    addr_seen = 1'b0;
    do_reset();
    instr_ready = 1'b0; run = 1'b1;
    repeat (20) step();
    total++; if (instr_valid !== 1'b1 || instr !== 16'h1122 || instr_pc !== 8'h00) begin
      bad++; $display("FAIL bp_head got=%b %h@%h want=1 1122@00", instr_valid, instr, instr_pc); end
    total++; if (mem_out_en !== 1'b0) begin bad++; $display("FAIL bp_idle_oe got=%b want=0", mem_out_en); end
    repeat (3) step();
    total++; if (mem_out_en !== 1'b0) begin bad++; $display("FAIL bp_idle_oe2 got=%b want=0", mem_out_en); end
    instr_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) begin wq.push_back(instr); pq.push_back(instr_pc); end
      step();
      if (!addr_seen && mem_out_en) begin
        addr_seen = 1'b1;
        total++; if (mem_address !== 8'h04) begin bad++; $display("FAIL bp_resume_addr got=%h want=04", mem_address); end
      end
      if (wq.size() >= 2) break;
    end
    total++; if (!addr_seen) begin bad++; $display("FAIL bp_resume got=none want=fetch at 04"); end
    total++;
    if (wq.size() < 2) begin bad++; $display("FAIL bp_drain got=%0d want=2", wq.size()); end
    else if (wq[0] !== 16'h1122 || pq[0] !== 8'h00 || wq[1] !== 16'h3344 || pq[1] !== 8'h02) begin
      bad++; $display("FAIL bp_drain got=%h@%h,%h@%h want=1122@00,3344@02", wq[0], pq[0], wq[1], pq[1]); end
  endtask

  task automatic test_branch();
    bit found, got;
    found = 1'b0; got = 1'b0;
    do_reset();
    instr_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (mem_out_en && mem_address == 8'h05) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL br_setup got=none want=ADDR at 05"); end
    branch_valid = 1'b1; branch_target = 8'h0A;
    step();
    branch_valid = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL br_flush got=%b want=0", instr_valid); end
    for (int i = 0; i < 40; i++) begin
      step();
      if (instr_valid) begin got = 1'b1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL br_timeout got=none want=instr@0a"); end
    else if (instr !== exp_word(8'h0A) || instr_pc !== 8'h0A) begin
      bad++; $display("FAIL br_target got=%h@%h want=%h@0a", instr, instr_pc, exp_word(8'h0A)); end
  endtask

  task automatic test_wrap();
    logic [DB-1:0] s0, sff;
    logic [15:0] wq[$];
    logic [7:0]  pq[$];
    s0 = ram[0]; sff = ram[255];
    ram[255] = 8'hAB; ram[0] = 8'hCD;
    do_reset();
    instr_ready = 1'b1; run = 1'b1; branch_valid = 1'b1; branch_target = 8'hFF;
    step();
    branch_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (instr_valid) begin wq.push_back(instr); pq.push_back(instr_pc); end
      if (wq.size() >= 2) break;
    end
    total++;
    if (wq.size() < 2) begin bad++; $display("FAIL wrap_timeout got=%0d want=2", wq.size()); end
    else begin
      total++; if (wq[0] !== 16'hABCD || pq[0] !== 8'hFF) begin bad++; $display("FAIL wrap_i0 got=%h@%h want=abcd@ff", wq[0], pq[0]); end
      total++; if (wq[1] !== 16'h2233 || pq[1] !== 8'h01) begin bad++; $display("FAIL wrap_i1 got=%h@%h want=2233@01", wq[1], pq[1]); end
    end
    ram[0] = s0; ram[255] = sff;
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found, got;
    found = 1'b0; got = 1'b0;
    do_reset();
    instr_ready = 1'b0; run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_out_en && mem_address == 8'h02) begin found = 1'b1; break; end
    end
    total++; if (!found || instr_valid !== 1'b1) begin bad++; $display("FAIL rm_setup got=%b/%b want=1/1", found, instr_valid); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (mem_address !== 8'h00 || mem_out_en !== 1'b0) begin
      bad++; $display("FAIL rm_mem got=%h/%b want=00/0", mem_address, mem_out_en); end
    total++; if (instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 8'h0) begin
      bad++; $display("FAIL rm_out got=%b %h@%h want=0 0000@00", instr_valid, instr, instr_pc); end
    instr_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (instr_valid) begin got = 1'b1; break; end
    end
    total++;
    if (!got || instr !== 16'h1122 || instr_pc !== 8'h00) begin
      bad++; $display("FAIL rm_restart got=%b %h@%h want=1 1122@00", got, instr, instr_pc); end
  endtask

  task automatic test_random();
    logic [AB-1:0] exp_pc;
    bit prev_br, br;
    int pops;
    exp_pc = '0; prev_br = 1'b0; pops = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_br) begin
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%b want=0", cyc, instr_valid); end
      end
      if (!instr_valid) begin
        total++; if (instr !== '0 || instr_pc !== '0) begin bad++; $display("FAIL rnd_empty cyc=%0d got=%h@%h want=0@0", cyc, instr, instr_pc); end
      end
      run = ($urandom_range(9) < 7);
      instr_ready = ($urandom_range(2) != 0);
      br = ($urandom_range(39) == 0);
      branch_valid = br;
      branch_target = AB'($urandom);
      if (instr_valid && instr_ready && !br) begin
        total++;
        if (instr !== exp_word(exp_pc) || instr_pc !== exp_pc) begin
          bad++; $display("FAIL rnd_pop cyc=%0d got=%h@%h want=%h@%h", cyc, instr, instr_pc, exp_word(exp_pc), exp_pc); end
        exp_pc = exp_pc + AB'(IB);
        pops++;
      end
      if (br) exp_pc = branch_target;
      prev_br = br;
      step();
    end
    branch_valid = 1'b0;
    total++; if (pops < 100) begin bad++; $display("FAIL rnd_progress got=%0d want>=100", pops); end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    int seen;
    seen = 0;
    do_reset();
    total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL stats_reset got=%0d want=0", fetch_count); end
    instr_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 100 && seen < 3; i++) begin
      step();
      if (instr_valid) seen++;
    end
    branch_valid = 1'b1; branch_target = 8'h20;
    step();
    branch_valid = 1'b0;
    for (int i = 0; i < 100 && seen < 4; i++) begin
      step();
      if (instr_valid) seen++;
    end
    total++; if (seen != 4 || fetch_count !== 16'd4) begin
      bad++; $display("FAIL stats_count got=%0d (seen %0d) want=4", fetch_count, seen); end
    run = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = DB'($urandom);
    for (int i = 0; i < 8; i++) ram[i] = DB'((i + 1) * 17);
    reset = 1'b1; run = 1'b0; branch_valid = 1'b0; instr_ready = 1'b0; branch_target = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_branch();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder and the consumer of the `ram` block's read port.
- Walks a program counter through RAM one byte per access and assembles INSTR_BYTES bytes into one instruction word.
- Queues completed instructions, each tagged with its start address, in a small FIFO with a valid/ready handshake to the decoder.
- Supports branch redirect with a full flush.

Parameters:
- ADDR_BITS, 8, RAM address width and PC width.
- DATA_BITS, 8, RAM word width.
- INSTR_BYTES, 2, RAM words per instruction; range 1..4.
- FIFO_DEPTH, 2, instruction queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  fetch enable; 0 pauses fetching.
- branch_valid  in  1  redirect request, sampled on the clock edge.
- branch_target  in  ADDR_BITS  new PC when branch_valid=1.
- mem_address  out  ADDR_BITS  RAM address.
- mem_out_en  out  1  RAM read enable.
- mem_write_en  out  1  RAM write enable; constant 0.
- mem_data  in  DATA_BITS  RAM read data.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decoder accepts the head.
- instr  out  INSTR_BYTES*DATA_BITS  head instruction word.
- instr_pc  out  ADDR_BITS  address of the head instruction's first byte.

Behaviour:
- Reset values, taking effect on the edge where reset=1:
  - pc=0, byte_idx=0, state=IDLE, FIFO empty.
  - mem_address=0, mem_out_en=0, mem_write_en=0.
  - instr_valid=0, instr=0, instr_pc=0.
- Reset has priority over every other input, including mid-access. Any partial instruction is discarded.
- All outputs are registered.
- State machine:
  - IDLE: mem_out_en=0.
    - Go to ADDR if run=1 and (byte_idx!=0 or FIFO count<FIFO_DEPTH).
    - Otherwise stay in IDLE.
  - ADDR: mem_address=pc, mem_out_en=1. Go to CAPTURE.
  - CAPTURE: mem_address and mem_out_en held. On the exiting edge:
    - mem_data is latched into assembly slot byte_idx. Byte 0 is the most significant byte.
    - pc=pc+1, modulo 2^ADDR_BITS.
    - If byte_idx==INSTR_BYTES-1: push {assembly, start_pc} into the FIFO and set byte_idx=0. Otherwise byte_idx++.
    - Next state is ADDR under the same condition as IDLE, otherwise IDLE.
- Throughput: 2 cycles per byte.
- Latency: the first instr_valid rises on the (2*INSTR_BYTES+1)th rising edge after run is first sampled high in IDLE.
- Space check:
  - Evaluated only at instruction start (byte_idx==0).
  - Counts the current FIFO occupancy, including a pop on the same edge.
  - A started instruction always completes unless run drops or a branch occurs, so a push never overflows.
- run=0 mid-instruction: the current CAPTURE still completes, then the block goes to IDLE holding byte_idx and assembly. Resuming continues at the next byte.
- FIFO:
  - A pop occurs when instr_valid&&instr_ready.
  - A simultaneous push and pop leaves the count unchanged and preserves order.
  - instr and instr_pc are the head entry, or 0 when empty.
- Branch (branch_valid=1 at an edge, reset=0):
  - FIFO cleared, pc=branch_target, byte_idx=0, state=IDLE.
  - The in-flight byte is discarded.
  - A pop or push on the same edge is ignored.
  - instr_valid=0 after that edge.
- PC wrap:
  - An instruction may straddle 2^ADDR_BITS-1 → 0.
  - instr_pc is the address of its first byte.

Optional Feature:
- Macro: FETCH_STATS_EN.
- When defined, adds output fetch_count [15:0]:
  - Increments on every FIFO push and wraps at 16 bits.
  - Reset to 0 by reset only; unaffected by branch.
  - Flushed instructions still count, since they were pushed.
- When undefined, the port and counter do not exist.

Test Plan:
- Default parameters, RAM[0..7]=0x11,0x22,...,0x88, run=1, instr_ready=1 → after reset:
  - First instr=0x1122, instr_pc=0, valid on the 5th edge after run.
  - Then 0x3344@2 and 0x5566@4, in order.
- instr_ready=0, run=1 → FIFO holds 0x1122@0 and 0x3344@2, state IDLE, mem_out_en=0. Then instr_ready=1 → both drain in order, and the next fetch starts at address 4.
- branch_valid with target 0x0A, asserted on the edge after byte 0 of the instruction at 4 is captured → instr_valid=0 next cycle; the next delivered instr is RAM[0x0A..0x0B] with instr_pc=0x0A.
- Branch to 0xFF, RAM[0xFF]=0xAB, RAM[0x00]=0xCD → instr=0xABCD, instr_pc=0xFF; the following instruction has instr_pc=0x01.
- reset=1 during CAPTURE with one FIFO entry present → after that edge, all outputs are at reset values and the FIFO is empty. Fetch restarts at address 0 after reset=0.
- With FETCH_STATS_EN: 3 pushes, then a branch, then 1 push → fetch_count=4. Without the macro, the build elaborates with no fetch_count port.
